// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, splitting each
// word/half/byte transaction into little-endian byte accesses. Define ARB_ROUND_ROBIN_EN for tie alternation.
module mem_port_arbiter #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   input  logic              if_flush_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_len_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ram_a_q;
   logic              wr_q;
   logic [7:0]        dout_q;
   logic [1:0]        cnt_q, last_q;
   logic [31:0]       wdata_q, buf_q, if_inst_q, mem_rdata_q;
   logic              if_done_q, mem_done_q;
   logic              if_ok, mem_ok, gnt_if, gnt_mem, at_last;
`ifdef ARB_ROUND_ROBIN_EN
   logic              last_mem_q;
`endif

   function automatic logic [1:0] last_idx(input logic [1:0] len);
      case (len)
         2'b00:   last_idx = 2'd0;
         2'b01:   last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
      merge_lane = word;
      merge_lane[{lane, 3'b000} +: 8] = b;
   endfunction

   function automatic logic [7:0] lane_of(input logic [31:0] word, input logic [1:0] lane);
      lane_of = word[{lane, 3'b000} +: 8];
   endfunction

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)   state_q <= IDLE;
      else if (rdy) state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (gnt_mem)    state_d = mem_we_i ? MEM_WR : MEM_RD;
                  else if (gnt_if) state_d = IF_RD;
         IF_RD:   if (if_flush_i || at_last) state_d = IDLE;
         default: if (at_last)    state_d = IDLE;
      endcase
   end

   // A requester whose done is still showing is dropping its request, so it must not win.
   always_comb begin
      mem_ok  = mem_req_i & ~mem_done_q;
      if_ok   = if_req_i & ~if_done_q & ~if_flush_i;
      gnt_mem = 1'b0;
      gnt_if  = 1'b0;
      if (state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (mem_ok && if_ok) begin
            gnt_mem = ~last_mem_q;
            gnt_if  = last_mem_q;
         end else begin
            gnt_mem = mem_ok;
            gnt_if  = if_ok;
         end
`else
         gnt_mem = mem_ok;
         gnt_if  = if_ok & ~mem_ok;
`endif
      end
      at_last  = (state_q != IDLE) && (cnt_q == last_q);
      ram_wr_o = wr_q & rdy;
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last_mem_q <= 1'b0;
      else if (rdy && state_q == IDLE && mem_ok && if_ok) last_mem_q <= gnt_mem;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_a_q     <= '0;
         wr_q        <= 1'b0;
         dout_q      <= 8'h00;
         cnt_q       <= 2'd0;
         last_q      <= 2'd0;
         if_inst_q   <= 32'h0;
         mem_rdata_q <= 32'h0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
      end else if (rdy) begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (gnt_mem) begin
               ram_a_q <= mem_addr_i;
               cnt_q   <= 2'd0;
               last_q  <= last_idx(mem_len_i);
               wr_q    <= mem_we_i;
               dout_q  <= mem_wdata_i[7:0];
            end else if (gnt_if) begin
               ram_a_q <= if_addr_i;
               cnt_q   <= 2'd0;
               last_q  <= 2'd3;
               wr_q    <= 1'b0;
            end
         end else if (state_q == IF_RD && if_flush_i) begin
            wr_q <= 1'b0;
         end else if (at_last) begin
            wr_q <= 1'b0;
            if (state_q == IF_RD) begin
               if_inst_q <= merge_lane(buf_q, cnt_q, ram_din_i);
               if_done_q <= 1'b1;
            end else begin
               if (state_q == MEM_RD) mem_rdata_q <= merge_lane(buf_q, cnt_q, ram_din_i);
               mem_done_q <= 1'b1;
            end
         end else begin
            cnt_q   <= cnt_q + 2'd1;
            ram_a_q <= ram_a_q + ADDR_W'(1);
            dout_q  <= lane_of(wdata_q, cnt_q + 2'd1);
         end
      end
   end

   // Assembly buffer is cleared while idle so unused lanes of short loads read as zero.
   always_ff @(posedge clk)
      if (rdy) begin
         if (state_q == IDLE) begin
            wdata_q <= mem_wdata_i;
            buf_q   <= 32'h0;
         end else if (state_q != MEM_WR) begin
            buf_q <= merge_lane(buf_q, cnt_q, ram_din_i);
         end
      end

   assign ram_a_o     = ram_a_q;
   assign ram_dout_o  = dout_q;
   assign if_inst_o   = if_inst_q;
   assign if_done_o   = if_done_q;
   assign mem_rdata_o = mem_rdata_q;
   assign mem_done_o  = mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level RAM/result model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n, rdy;
   logic        if_req_i, if_flush_i, mem_req_i, mem_we_i;
   logic [1:0]  mem_len_i;
   logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
   logic [31:0] if_inst_o, mem_rdata_o, ram_a_o;
   logic        if_done_o, mem_done_o, ram_wr_o;
   logic [7:0]  ram_dout_o;
   wire  [7:0]  ram_din_i;

   mem_port_arbiter #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
      .if_inst_o(if_inst_o), .if_done_o(if_done_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
      .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
      .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
   );

   always #5 clk = ~clk;

   // 64 KiB RAM mirrored across the 32-bit space; ref_mem is the expected content.
   logic [7:0]  ram     [65536];
   logic [7:0]  ref_mem [65536];
   logic        tb_we = 1'b0;
   logic [15:0] tb_wa = 16'h0;
   logic [7:0]  tb_wd = 8'h0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (tb_we) ram[tb_wa] <= tb_wd;
      else if (ram_wr_o) begin
         ram[ram_a_o[15:0]] <= ram_dout_o;
         wr_cnt <= wr_cnt + 1;
      end
   end
   assign ram_din_i = ram[ram_a_o[15:0]];

   int          errors = 0, checks = 0;
   logic [31:0] exp_if_inst = 32'h0, exp_mem_rdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
   bit          tie_last_mem = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int n_of(input logic [1:0] len);
      return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] assemble(input logic [31:0] base, input int n);
      logic [31:0] w, a;
      w = 32'h0;
      for (int i = 0; i < n; i++) begin
         a = base + 32'(i);
         w = w | (32'(ref_mem[a[15:0]]) << (8 * i));
      end
      return w;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      ref_mem[a[15:0]] = d;
      tb_we = 1'b1; tb_wa = a[15:0]; tb_wd = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Entered mid-cycle right after the grant edge; walks the transaction to its done pulse.
   task automatic follow(input bit is_mem, input bit we, input int n, input logic [31:0] base,
                         input logic [31:0] wdata, input int stall_at, input int stall_len);
      int k, stalls, lat, wc0;
      bit r;
      logic [31:0] sh, a;
      k = 0; stalls = 0; lat = 0; wc0 = wr_cnt;
      while (k < n && lat < 64) begin
         r = !(k == stall_at && stalls < stall_len);
         if (!r) stalls++;
         rdy = r;
         #1;
         check_val("addr", ram_a_o, base + 32'(k));
         check_val("wr_strobe", 32'(ram_wr_o), (is_mem && we) ? 32'(r) : 32'h0);
         if (is_mem && we) begin
            sh = wdata >> (8 * k);
            check_val("wr_byte", 32'(ram_dout_o), {24'h0, sh[7:0]});
         end
         check_val("busy_done", 32'({if_done_o, mem_done_o}), 32'h0);
         @(negedge clk);
         lat++;
         if (r) k++;
      end
      rdy = 1'b1;
      check_val("latency", 32'(lat), 32'(n + ((stall_at < n) ? stall_len : 0)));
      check_val("done", is_mem ? 32'({mem_done_o, if_done_o}) : 32'({if_done_o, mem_done_o}), 32'h2);
      if (!is_mem) exp_if_inst = assemble(base, 4);
      else if (!we) exp_mem_rdata = assemble(base, n);
      else begin
         check_val("wr_count", 32'(wr_cnt - wc0), 32'(n));
         for (int i = 0; i < n; i++) begin
            a = base + 32'(i);
            check_val("ram_byte", 32'(ram[a[15:0]]), 32'(ref_mem[a[15:0]]));
         end
      end
      check_val("if_inst", if_inst_o, exp_if_inst);
      check_val("mem_rdata", mem_rdata_o, exp_mem_rdata);
      if (is_mem) mem_req_i = 1'b0; else if_req_i = 1'b0;
   endtask

   task automatic txn(input bit is_mem, input bit we, input logic [1:0] len, input logic [31:0] base,
                      input logic [31:0] wdata, input int stall_at, input int stall_len);
      int n;
      logic [31:0] a, sh;
      n = is_mem ? n_of(len) : 4;
      if (is_mem && we)
         for (int i = 0; i < n; i++) begin
            a = base + 32'(i); sh = wdata >> (8 * i);
            ref_mem[a[15:0]] = sh[7:0];
         end
      if (is_mem) begin
         mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = base; mem_wdata_i = wdata;
      end else begin
         if_req_i = 1'b1; if_addr_i = base;
      end
      rdy = 1'b1;
      @(negedge clk);
      follow(is_mem, we, n, base, wdata, stall_at, stall_len);
      @(negedge clk);
      check_val("done_pulse", 32'({if_done_o, mem_done_o}), 32'h0);
   endtask

   task automatic tie(input logic [31:0] maddr, input logic [31:0] iaddr);
      bit wm;
`ifdef ARB_ROUND_ROBIN_EN
      wm = !tie_last_mem;
      tie_last_mem = wm;
`else
      wm = 1'b1;
`endif
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b10; mem_addr_i = maddr;
      if_req_i = 1'b1; if_addr_i = iaddr; rdy = 1'b1;
      @(negedge clk);
      if (wm) begin
         follow(1'b1, 1'b0, 4, maddr, 32'h0, 9, 0);
         @(negedge clk);
         follow(1'b0, 1'b0, 4, iaddr, 32'h0, 9, 0);
      end else begin
         follow(1'b0, 1'b0, 4, iaddr, 32'h0, 9, 0);
         @(negedge clk);
         follow(1'b1, 1'b0, 4, maddr, 32'h0, 9, 0);
      end
      @(negedge clk);
      check_val("tie_done_pulse", 32'({if_done_o, mem_done_o}), 32'h0);
   endtask

   initial begin
      logic [31:0] base, wdata, prev_a, a;
      bit is_mem, we;
      logic [1:0] len;
      int sel, stall_at;

      rst_n = 1'b0; rdy = 1'b1; if_req_i = 1'b0; if_flush_i = 1'b0; mem_req_i = 1'b0;
      mem_we_i = 1'b0; mem_len_i = 2'b00; if_addr_i = 32'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      check_val("rst_ram_a", ram_a_o, 32'h0);
      check_val("rst_ram_wr", 32'(ram_wr_o), 32'h0);
      check_val("rst_ram_dout", 32'(ram_dout_o), 32'h0);
      check_val("rst_if_inst", if_inst_o, 32'h0);
      check_val("rst_mem_rdata", mem_rdata_o, 32'h0);
      check_val("rst_dones", 32'({if_done_o, mem_done_o}), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         poke(32'h0000 + 32'(i), 8'($urandom));
         poke(32'h1000 + 32'(i), 8'($urandom));
         poke(32'hFF00 + 32'(i), 8'($urandom));
      end

      poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h10); poke(32'h1003, 8'h00);
      txn(1'b0, 1'b0, 2'b00, 32'h1000, 32'h0, 9, 0);
      check_val("fetch_word", if_inst_o, 32'h00100513);

      txn(1'b1, 1'b1, 2'b00, 32'h20, 32'h123456AB, 9, 0);
      check_val("store_byte", 32'(ram[16'h0020]), 32'hAB);

      poke(32'hFFFFFFFF, 8'h80); poke(32'h0, 8'hFF);
      txn(1'b1, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 9, 0);
      check_val("half_wrap", mem_rdata_o, 32'h0000FF80);

      tie(32'h0010, 32'h1040);
      tie(32'h0030, 32'h1080);

      // Abort a fetch after two bytes, then confirm flush also blocks an idle grant.
      if_req_i = 1'b1; if_addr_i = 32'h1020; rdy = 1'b1;
      repeat (3) @(negedge clk);
      if_flush_i = 1'b1;
      @(negedge clk);
      check_val("flush_no_done", 32'(if_done_o), 32'h0);
      check_val("flush_inst_hold", if_inst_o, exp_if_inst);
      if_req_i = 1'b0;
      @(negedge clk);
      check_val("flush_no_late_done", 32'(if_done_o), 32'h0);
      check_val("flush_inst_hold2", if_inst_o, exp_if_inst);
      prev_a = ram_a_o;
      if_req_i = 1'b1; if_addr_i = 32'h10A0;
      @(negedge clk);
      check_val("flush_blocks_grant", ram_a_o, prev_a);
      if_flush_i = 1'b0;
      @(negedge clk);
      follow(1'b0, 1'b0, 4, 32'h10A0, 32'h0, 9, 0);
      @(negedge clk);

      txn(1'b1, 1'b1, 2'b10, 32'h1010, 32'hCAFEF00D, 1, 3);
      check_val("stall_b0", 32'(ram[16'h1010]), 32'h0D);
      check_val("stall_b3", 32'(ram[16'h1013]), 32'hCA);

      for (int t = 0; t < 40; t++) begin
         is_mem = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         len = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 2);
         base = (sel == 0) ? 32'($urandom_range(0, 251)) :
                (sel == 1) ? 32'h1000 + 32'($urandom_range(0, 251)) :
                             32'hFFFFFF00 + 32'($urandom_range(0, 255));
         wdata = $urandom;
         stall_at = $urandom_range(0, 3);
         txn(is_mem, we, len, base, wdata, stall_at, $urandom_range(0, 3));
      end

      // Reset in the middle of a word store: the first two bytes stay written.
      wdata = $urandom;
      for (int i = 0; i < 2; i++) begin
         a = wdata >> (8 * i);
         ref_mem[16'h0040 + 16'(i)] = a[7:0];
      end
      sel = wr_cnt;
      mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10; mem_addr_i = 32'h40; mem_wdata_i = wdata;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_wr", 32'(ram_wr_o), 32'h0);
      check_val("mid_rst_addr", ram_a_o, 32'h0);
      check_val("mid_rst_done", 32'({if_done_o, mem_done_o}), 32'h0);
      check_val("mid_rst_inst", if_inst_o, 32'h0);
      mem_req_i = 1'b0; exp_if_inst = 32'h0; exp_mem_rdata = 32'h0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("mid_rst_wr_count", 32'(wr_cnt - sel), 32'h2);
      for (int i = 0; i < 4; i++)
         check_val("mid_rst_ram", 32'(ram[16'h0040 + 16'(i)]), 32'(ref_mem[16'h0040 + 16'(i)]));
      @(negedge clk);
      txn(1'b0, 1'b0, 2'b00, 32'h1004, 32'h0, 2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
